// File: rtl/ysyx_22040127_arb_pkg.sv
// rtl/ysyx_22040127_arb_pkg.sv - shared types and constants for the cache memory arbiter
package ysyx_22040127_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WDATA = 3'd4,
        WRESP = 3'd5
    } arb_state_e;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } owner_e;

    localparam logic [2:0] AXI_SIZE_8B = 3'd3;

endpackage

// File: rtl/ysyx_22040127_rr_arb2.sv
// rtl/ysyx_22040127_rr_arb2.sv - two-requester round-robin grant with remembered last owner
module ysyx_22040127_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic ic_req_i,
    input  logic dc_req_i,
    output logic ic_gnt_o,
    output logic dc_gnt_o
);
    import ysyx_22040127_arb_pkg::*;

    owner_e last_owner_q;
    owner_e last_owner_d;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        ic_gnt_o = 1'b0;
        dc_gnt_o = 1'b0;
        if (en_i) begin
            if (ic_req_i && dc_req_i) begin
                if (last_owner_q == IC) begin
                    dc_gnt_o = 1'b1;
                end else begin
                    ic_gnt_o = 1'b1;
                end
            end else begin
                ic_gnt_o = ic_req_i;
                dc_gnt_o = dc_req_i;
            end
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (dc_gnt_o) begin
            last_owner_d = DC;
        end else if (ic_gnt_o) begin
            last_owner_d = IC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= IC;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: rtl/ysyx_22040127_mem_arbiter.sv
// rtl/ysyx_22040127_mem_arbiter.sv - shares one AXI4-subset port between icache refill and dcache refill/writeback
module ysyx_22040127_mem_arbiter #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 64,
    parameter  int LEN_W  = 8,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    input  logic [LEN_W-1:0]  ic_req_len,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_we,
    input  logic [LEN_W-1:0]  dc_req_len,
    input  logic [2:0]        dc_req_size,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic [STRB_W-1:0] dc_wstrb,
    output logic              dc_wready,
    output logic              dc_bvalid,
    output logic              ic_rvalid,
    output logic              dc_rvalid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              axi_arvalid,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic [LEN_W-1:0]  axi_arlen,
    output logic [2:0]        axi_arsize,
    input  logic              axi_arready,
    input  logic              axi_rvalid,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic              axi_rlast,
    output logic              axi_rready,
    output logic              axi_awvalid,
    output logic [ADDR_W-1:0] axi_awaddr,
    output logic [LEN_W-1:0]  axi_awlen,
    output logic [2:0]        axi_awsize,
    input  logic              axi_awready,
    output logic              axi_wvalid,
    output logic [DATA_W-1:0] axi_wdata,
    output logic [STRB_W-1:0] axi_wstrb,
    output logic              axi_wlast,
    input  logic              axi_wready,
    input  logic              axi_bvalid,
    output logic              axi_bready
);
    import ysyx_22040127_arb_pkg::*;

    arb_state_e        state_q;
    owner_e            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [2:0]        size_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;

    logic ic_gnt;
    logic dc_gnt;
    logic arb_en;
    logic rbeat;

    assign arb_en = (state_q == IDLE) && !rst;

    ysyx_22040127_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .en_i     (arb_en),
        .ic_req_i (ic_req_valid),
        .dc_req_i (dc_req_valid),
        .ic_gnt_o (ic_gnt),
        .dc_gnt_o (dc_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= IC;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            cnt_q     <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (ic_gnt) begin
                        owner_q   <= IC;
                        addr_q    <= ic_req_addr;
                        len_q     <= ic_req_len;
                        size_q    <= AXI_SIZE_8B;
                        arvalid_q <= 1'b1;
                        state_q   <= RADDR;
                    end else if (dc_gnt) begin
                        owner_q <= DC;
                        addr_q  <= dc_req_addr;
                        len_q   <= dc_req_len;
                        size_q  <= dc_req_size;
                        if (dc_req_we) begin
                            awvalid_q <= 1'b1;
                            state_q   <= WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RADDR;
                        end
                    end
                end
                RADDR: begin
                    if (axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RDATA;
                    end
                end
                RDATA: begin
                    if (axi_rvalid && axi_rlast) begin
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                WADDR: begin
                    if (axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state_q   <= WDATA;
                    end
                end
                WDATA: begin
                    // Leaves on the last beat, so the counter never needs to wrap.
                    if (axi_wready) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (axi_bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ic_req_ready = ic_gnt;
    assign dc_req_ready = dc_gnt;

    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = arvalid_q ? addr_q : '0;
    assign axi_arlen   = arvalid_q ? len_q  : '0;
    assign axi_arsize  = arvalid_q ? size_q : '0;
    assign axi_rready  = rready_q;

    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = awvalid_q ? addr_q : '0;
    assign axi_awlen   = awvalid_q ? len_q  : '0;
    assign axi_awsize  = awvalid_q ? size_q : '0;

    assign axi_wvalid = wvalid_q;
    assign axi_wdata  = wvalid_q ? dc_wdata : '0;
    assign axi_wstrb  = wvalid_q ? dc_wstrb : '0;
    assign axi_wlast  = wvalid_q && (cnt_q == len_q);
    assign dc_wready  = wvalid_q && axi_wready;

    assign axi_bready = bready_q;
    assign dc_bvalid  = bready_q && axi_bvalid;

    // Read beats are forwarded in the same cycle; the caches never stall them.
    assign rbeat     = rready_q && axi_rvalid;
    assign ic_rvalid = rbeat && (owner_q == IC);
    assign dc_rvalid = rbeat && (owner_q == DC);
    assign rsp_data  = rbeat ? axi_rdata : '0;
    assign rsp_last  = rbeat && axi_rlast;

endmodule

// File: tb/tb_ysyx_22040127_mem_arbiter.sv
// tb/tb_ysyx_22040127_mem_arbiter.sv - randomized bench for the cache memory arbiter with a transaction-level model
module tb_ysyx_22040127_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req_valid, ic_req_ready;
    logic [31:0] ic_req_addr;
    logic [7:0]  ic_req_len;
    logic        dc_req_valid, dc_req_ready;
    logic [31:0] dc_req_addr;
    logic        dc_req_we;
    logic [7:0]  dc_req_len;
    logic [2:0]  dc_req_size;
    logic [63:0] dc_wdata;
    logic [7:0]  dc_wstrb;
    logic        dc_wready, dc_bvalid, ic_rvalid, dc_rvalid;
    logic [63:0] rsp_data;
    logic        rsp_last;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic        axi_rvalid, axi_rlast, axi_rready;
    logic [63:0] axi_rdata;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic        axi_wvalid, axi_wlast, axi_wready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;

    always #5 clk = ~clk;

    ysyx_22040127_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
        .ic_req_addr(ic_req_addr), .ic_req_len(ic_req_len),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
        .dc_req_len(dc_req_len), .dc_req_size(dc_req_size),
        .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_wready(dc_wready),
        .dc_bvalid(dc_bvalid), .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid),
        .rsp_data(rsp_data), .rsp_last(rsp_last),
        .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arready(axi_arready),
        .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast),
        .axi_rready(axi_rready),
        .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast), .axi_wready(axi_wready),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: which requester owns the bus and how far its burst has progressed.
    bit          m_busy, m_we, m_adone, m_wdone, m_own, m_last;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic [2:0]  m_size;
    int          m_beat, arv_cyc, beats, n_bv, n_issued;
    bit          gnt_log[$];

    bit          ic_took, dc_took, keep_both, gen_en, zchk;
    logic [31:0] wb_addr;
    int          dc_k;

    int s_rrem, s_ar_age, s_ar_wait, s_aw_age, s_aw_wait, wmode;
    bit s_bpend, wtog;

    function automatic logic [63:0] pat(input logic [31:0] a, input int k);
        return {a, ~a} ^ (64'h9e37_79b9_7f4a_7c15 * 64'(k + 1));
    endfunction

    function automatic logic [7:0] spat(input logic [31:0] a, input int k);
        return a[7:0] ^ 8'(k * 37 + 1);
    endfunction

    task automatic reset_env();
        m_busy = 0; m_we = 0; m_adone = 0; m_wdone = 0; m_own = 0; m_last = 0; m_beat = 0;
        ic_took = 0; dc_took = 0; dc_k = 0;
        s_rrem = 0; s_ar_age = 0; s_aw_age = 0; s_bpend = 0; wtog = 1;
        s_ar_wait = $urandom_range(0, 3);
        s_aw_wait = $urandom_range(0, 3);
    endtask

    task automatic issue_ic(input logic [31:0] a, input logic [7:0] l);
        ic_req_valid = 1; ic_req_addr = a; ic_req_len = l; n_issued++;
    endtask

    task automatic issue_dc(input logic [31:0] a, input logic we, input logic [7:0] l, input logic [2:0] s);
        dc_req_valid = 1; dc_req_addr = a; dc_req_we = we; dc_req_len = l; dc_req_size = s; n_issued++;
    endtask

    task automatic check_zero(input string tag);
        expect_eq({tag, "_ctrl"}, 64'({ic_req_ready, dc_req_ready, dc_wready, dc_bvalid, ic_rvalid,
                  dc_rvalid, rsp_last, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid,
                  axi_wlast, axi_bready}), 64'(0));
        expect_eq({tag, "_addr"}, {axi_araddr, axi_awaddr}, 64'(0));
        expect_eq({tag, "_fields"}, 64'({axi_arlen, axi_arsize, axi_awlen, axi_awsize, axi_wstrb}), 64'(0));
        expect_eq({tag, "_wdata"}, axi_wdata, 64'(0));
        expect_eq({tag, "_rdata"}, rsp_data, 64'(0));
    endtask

    // Runs at the falling edge: compare against the model, then advance model, caches and slave.
    task automatic step();
        bit e_arv, e_awv, e_rr, e_wv, e_br, rbeat, e_gic, e_gdc;
        if (zchk) begin
            check_zero("zero");
            zchk = 0;
        end
        e_arv = m_busy && !m_we && !m_adone;
        e_awv = m_busy && m_we && !m_adone;
        e_rr  = m_busy && !m_we && m_adone;
        e_wv  = m_busy && m_we && m_adone && !m_wdone;
        e_br  = m_busy && m_we && m_wdone;
        expect_eq("arvalid", 64'(axi_arvalid), 64'(e_arv));
        expect_eq("awvalid", 64'(axi_awvalid), 64'(e_awv));
        expect_eq("rready", 64'(axi_rready), 64'(e_rr));
        expect_eq("wvalid", 64'(axi_wvalid), 64'(e_wv));
        expect_eq("bready", 64'(axi_bready), 64'(e_br));
        if (e_arv) begin
            arv_cyc++;
            expect_eq("araddr", 64'(axi_araddr), 64'(m_addr));
            expect_eq("arlen_size", 64'({axi_arlen, axi_arsize}), 64'({m_len, m_size}));
        end
        if (e_awv) begin
            expect_eq("awaddr", 64'(axi_awaddr), 64'(m_addr));
            expect_eq("awlen_size", 64'({axi_awlen, axi_awsize}), 64'({m_len, m_size}));
        end
        rbeat = e_rr && axi_rvalid;
        expect_eq("ic_rvalid", 64'(ic_rvalid), 64'(rbeat && !m_own));
        expect_eq("dc_rvalid", 64'(dc_rvalid), 64'(rbeat && m_own));
        if (rbeat) begin
            expect_eq("rsp_data", rsp_data, axi_rdata);
            expect_eq("rsp_last", 64'(rsp_last), 64'(m_beat == int'(m_len)));
        end
        if (e_wv) begin
            expect_eq("wdata", axi_wdata, pat(m_addr, m_beat));
            expect_eq("wstrb", 64'(axi_wstrb), 64'(spat(m_addr, m_beat)));
            expect_eq("wlast", 64'(axi_wlast), 64'(m_beat == int'(m_len)));
        end
        expect_eq("dc_wready", 64'(dc_wready), 64'(e_wv && axi_wready));
        expect_eq("dc_bvalid", 64'(dc_bvalid), 64'(e_br && axi_bvalid));

        e_gic = 0;
        e_gdc = 0;
        if (!m_busy && !rst) begin
            if (ic_req_valid && dc_req_valid) begin
                e_gdc = !m_last;
                e_gic = m_last;
            end else begin
                e_gic = ic_req_valid;
                e_gdc = dc_req_valid;
            end
        end
        expect_eq("ic_req_ready", 64'(ic_req_ready), 64'(e_gic));
        expect_eq("dc_req_ready", 64'(dc_req_ready), 64'(e_gdc));

        if (rst) begin
            reset_env();
            return;
        end

        if (dc_bvalid) n_bv++;
        if ((e_arv && axi_arready) || (e_awv && axi_awready)) m_adone = 1;
        if (rbeat) begin
            beats++;
            if (m_beat == int'(m_len)) m_busy = 0;
            m_beat++;
        end
        if (e_wv && axi_wready) begin
            beats++;
            if (m_beat == int'(m_len)) m_wdone = 1;
            m_beat++;
        end
        if (e_br && axi_bvalid) m_busy = 0;
        if (e_gic || e_gdc) begin
            m_busy = 1; m_adone = 0; m_wdone = 0; m_beat = 0; arv_cyc = 0; beats = 0;
            m_own = e_gdc; m_last = e_gdc;
            gnt_log.push_back(e_gdc);
            if (e_gic) begin
                m_we = 0; m_addr = ic_req_addr; m_len = ic_req_len; m_size = 3'd3;
            end else begin
                m_we = dc_req_we; m_addr = dc_req_addr; m_len = dc_req_len; m_size = dc_req_size;
            end
        end

        if (ic_req_ready) ic_took = 1;
        if (dc_req_ready) begin
            dc_took = 1;
            wb_addr = dc_req_addr;
            dc_k = 0;
        end
        if (dc_wready) dc_k++;

        if (axi_arvalid && axi_arready) begin
            s_rrem = int'(axi_arlen) + 1; s_ar_age = 0; s_ar_wait = $urandom_range(0, 3);
        end else if (axi_arvalid) begin
            s_ar_age++;
        end
        if (axi_awvalid && axi_awready) begin
            s_aw_age = 0; s_aw_wait = $urandom_range(0, 3);
        end else if (axi_awvalid) begin
            s_aw_age++;
        end
        if (axi_rvalid && axi_rready) s_rrem--;
        if (axi_wvalid && axi_wready && axi_wlast) s_bpend = 1;
        if (axi_bvalid && axi_bready) s_bpend = 0;
    endtask

    // Runs just after the rising edge: caches and slave present new inputs.
    task automatic drive();
        if (ic_took) begin ic_req_valid = 0; ic_took = 0; end
        if (dc_took) begin dc_req_valid = 0; dc_took = 0; end
        if (keep_both) begin
            if (!ic_req_valid) issue_ic($urandom & 32'hffff_fff8, 8'($urandom_range(0, 3)));
            if (!dc_req_valid) issue_dc($urandom & 32'hffff_fff8, 1'b0, 8'($urandom_range(0, 3)), 3'd3);
        end else if (gen_en) begin
            if (!ic_req_valid && $urandom_range(0, 99) < 30)
                issue_ic($urandom & 32'hffff_fff8, 8'($urandom_range(0, 7)));
            if (!dc_req_valid && $urandom_range(0, 99) < 30)
                issue_dc($urandom & 32'hffff_fff8, 1'($urandom_range(0, 1)),
                         8'($urandom_range(0, 7)), 3'($urandom_range(0, 3)));
        end
        dc_wdata    = pat(wb_addr, dc_k);
        dc_wstrb    = spat(wb_addr, dc_k);
        axi_arready = axi_arvalid && (s_ar_age >= s_ar_wait);
        axi_awready = axi_awvalid && (s_aw_age >= s_aw_wait);
        axi_rvalid  = (s_rrem > 0) && ($urandom_range(0, 3) != 0);
        axi_rdata   = {$urandom, $urandom};
        axi_rlast   = axi_rvalid && (s_rrem == 1);
        case (wmode)
            1: begin
                if (axi_wvalid) begin
                    axi_wready = wtog;
                    wtog = !wtog;
                end else begin
                    axi_wready = 0;
                    wtog = 1;
                end
            end
            2:       axi_wready = 1;
            default: axi_wready = 1'($urandom_range(0, 1));
        endcase
        axi_bvalid = s_bpend && ($urandom_range(0, 2) != 0);
    endtask

    task automatic cycle();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_idle(input string tag, input int max);
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((m_busy || ic_req_valid || dc_req_valid) && n < max);
        expect_eq({tag, "_done"}, 64'(m_busy || ic_req_valid || dc_req_valid), 64'(0));
    endtask

    initial begin
        int base, n, bv0;
        bit reached;
        rst = 1;
        ic_req_valid = 0; ic_req_addr = 0; ic_req_len = 0;
        dc_req_valid = 0; dc_req_addr = 0; dc_req_we = 0; dc_req_len = 0; dc_req_size = 0;
        dc_wdata = 0; dc_wstrb = 0; wb_addr = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rlast = 0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
        keep_both = 0; gen_en = 0; zchk = 0; wmode = 0; n_issued = 0; n_bv = 0;
        arv_cyc = 0; beats = 0;
        reset_env();
        repeat (3) cycle();
        rst = 0;
        zchk = 1;
        cycle();

        // contention straight after reset: dcache first, icache in the next idle slot
        base = gnt_log.size();
        issue_ic(32'h8000_0100, 8'd0);
        issue_dc(32'h8000_0200, 1'b0, 8'd2, 3'd3);
        run_idle("t2", 200);
        expect_eq("t2_first_dc", 64'(gnt_log[base]), 64'(1));
        expect_eq("t2_second_ic", 64'(gnt_log[base + 1]), 64'(0));

        // dcache writeback with wready toggling 1010
        bv0 = n_bv;
        wmode = 1;
        issue_dc(32'h8000_1000, 1'b1, 8'd3, 3'd3);
        run_idle("t3", 200);
        expect_eq("t3_beats", 64'(beats), 64'(4));
        expect_eq("t3_bvalid_cnt", 64'(n_bv - bv0), 64'(1));
        wmode = 0;

        // icache read, arready after two cycles
        s_ar_wait = 2;
        issue_ic(32'h8000_0000, 8'd1);
        run_idle("t1", 200);
        expect_eq("t1_arv_cycles", 64'(arv_cyc), 64'(3));
        expect_eq("t1_beats", 64'(beats), 64'(2));

        // four rounds of back-to-back contention
        base = gnt_log.size();
        keep_both = 1;
        n = 0;
        while (gnt_log.size() < base + 4 && n < 500) begin
            cycle();
            n++;
        end
        keep_both = 0;
        expect_eq("t4_rounds", 64'(gnt_log.size() >= base + 4), 64'(1));
        for (int k = 0; k < 4; k++)
            if (gnt_log.size() > base + k)
                expect_eq($sformatf("t4_gnt%0d", k), 64'(gnt_log[base + k]), 64'((k % 2) == 0));
        run_idle("t4", 300);

        // reset while the second write beat is pending
        wmode = 2;
        issue_dc(32'h8000_2000, 1'b1, 8'd3, 3'd3);
        n = 0;
        reached = 0;
        while (n < 200 && !reached) begin
            cycle();
            n++;
            reached = m_busy && m_we && m_adone && (m_beat == 1);
        end
        expect_eq("t5_reach_wbeat2", 64'(reached), 64'(1));
        rst = 1;
        ic_req_valid = 0;
        dc_req_valid = 0;
        cycle();
        rst = 0;
        zchk = 1;
        wmode = 0;
        cycle();
        base = gnt_log.size();
        issue_ic(32'h8000_3000, 8'd3);
        run_idle("t5", 200);
        expect_eq("t5_ic_beats", 64'(beats), 64'(4));
        expect_eq("t5_ic_owner", 64'(gnt_log[base]), 64'(0));

        // dcache single-beat read with a 4-byte size code
        issue_dc(32'h8000_4444, 1'b0, 8'd0, 3'd2);
        run_idle("t6", 200);
        expect_eq("t6_beats", 64'(beats), 64'(1));

        gen_en = 1;
        repeat (3000) cycle();
        gen_en = 0;
        run_idle("rand", 1000);
        expect_eq("grant_count", 64'(gnt_log.size()), 64'(n_issued));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
